md_multipad_encoder: RTL and testbench
======================================

# md_multipad_encoder

Parametrised successor to the single-pad Mega Drive six-button encoder. It drives `NUM_PADS` independent DB9 controller ports from active-low button inputs. Each port decodes its own console select line (p7/TH) through the six-button multiplex sequence with a programmable inactivity timeout and a per-pad 3/6-button mode latched at reset. The block sits between the board's button/GPIO inputs and the DB9 pin drivers.

## Interface
Parameters:
- `NUM_PADS`, 2, number of independent controller ports.
- `SYNC_STAGES`, 2, flip-flop stages on every input (min 2).
- `TIMEOUT_CYCLES`, 16000, clk cycles without a TH falling edge before the sequence restarts (1.6 ms at 10 MHz).
- `DEBOUNCE_CYCLES`, 5000, stable-input cycles required when debounce is compiled in.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `p7` in NUM_PADS: TH select from the console, per pad.
- `up`, `dw`, `lf`, `rg`, `a`, `b`, `c`, `st`, `x`, `y`, `z`, `md` in NUM_PADS each: buttons, active-low (0 = pressed).
- `p1`, `p2`, `p3`, `p4`, `p6`, `p9` out NUM_PADS each: DB9 data pins, registered.

## Operation
- All inputs pass through `SYNC_STAGES` flip-flops. Edge detection uses the last two synchronised TH samples.
- Per pad state:
  - `fc`: 3-bit TH falling-edge count, 0..4, saturating at 4.
  - `tmr`: timeout counter, width `$clog2(TIMEOUT_CYCLES+1)`.
  - `six_en`: mode bit.
- On a synchronised TH falling edge: `fc <= min(fc+1,4)` and `tmr <= 0`.
- Otherwise, if `tmr == TIMEOUT_CYCLES-1`: `fc <= 0` and `tmr` holds. Otherwise `tmr` increments.
- If a falling edge and timeout expiry occur in the same cycle, the edge wins: `fc` increments and `tmr` clears.
- `six_en` is loaded from synchronised `md` on every cycle `rst` is high:
  - `md` = 1 selects six-button mode.
  - `md` = 0 (MODE held during reset) selects three-button mode.
- In three-button mode, `fc` is forced to 1 for output selection.
- Output mux, evaluated from synchronised TH and current `fc`:
  - TH=1, fc=3: p1..p4 = Z, Y, X, MD; p6=B; p9=C.
  - TH=1, any other fc: p1..p4 = UP, DW, LF, RG; p6=B; p9=C.
  - TH=0, fc ∈ {0,1,2}: p1=UP, p2=DW, p3=0, p4=0, p6=A, p9=ST.
  - TH=0, fc=3: p1..p4 = 0; p6=A; p9=ST.
  - TH=0, fc=4: p1..p4 = 1; p6=A; p9=ST.
- Pads are fully independent. No shared counters.
- TH pulses shorter than one clk period may be missed. That is acceptable and is not an error.

## Timing
- Reset values, for every pad:
  - All outputs = 1.
  - `fc` = 0, `tmr` = 0.
  - Synchroniser flops = 1.
- Reset mid-sequence returns the pad to fc=0 on the next cycle. No partial state survives.
- Latency from a TH or button pin change to the DB9 output: `SYNC_STAGES`+2 clk cycles (sync, edge/count, output register).
- With the defaults at 10 MHz this is 400 ns, within the console's settle time.
- The timeout is measured from the last falling edge. Rising edges do not restart it.

## Configuration
- `MD_DEBOUNCE_EN` defined:
  - Each of the 12 buttons per pad has a counter. The internal button value changes only after the synchronised input has differed from it for `DEBOUNCE_CYCLES` consecutive cycles.
  - Adds `DEBOUNCE_CYCLES` to button latency. TH latency is unchanged.
  - `six_en` sampling uses the raw synchronised `md`.
- `MD_DEBOUNCE_EN` undefined:
  - Synchronised buttons feed the mux directly.
  - `DEBOUNCE_CYCLES` is ignored and no counters are generated.

## Test plan
- Reset with all buttons released, TH=1 → every output reads 1 after reset. After releasing `rst`, press A+Start with TH=0 → p1=1, p2=1, p3=0, p4=0, p6=0, p9=0 within SYNC_STAGES+2 cycles.
- Six-button read, pad0, Z and MODE pressed: toggle TH 4 times at 2 µs per phase → third high phase gives p1=0, p2=1, p3=1, p4=0. Third low phase gives p1..p4=0000. Fourth low phase gives 1111.
- Timeout: after two falling edges, hold TH=1 for TIMEOUT_CYCLES+5 cycles, then run a full sequence → the ID pattern (p1..p4=0000) appears on the third low phase, not earlier.
- Three-button mode: hold md=0 through reset on pad1 only, then run a 4-pulse sequence on both pads → pad1 never shows 0000 or the XYZ/MODE data. Pad0 shows both.
- Reset asserted during the third high phase → outputs go to all 1 the cycle after `rst`. The next sequence starts at fc=0.
- With `MD_DEBOUNCE_EN` and DEBOUNCE_CYCLES=8: a 5-cycle glitch on `b` → p6 stays 1. Holding `b` low for 20 cycles → p6=0 at TH=1.

Source files
------------

// File: rtl/md_multipad_encoder.sv
// md_multipad_encoder: NUM_PADS independent Mega Drive six-button pad encoders.
// Each pad synchronises its inputs and counts TH falling edges to step through
// the six-button read sequence. An idle timeout restarts the sequence.
// Compile-time option MD_DEBOUNCE_EN adds a per-button debounce counter.

module md_pad_lane #(
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 16000,
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        th,
  input  logic [11:0] btn,   // {md,z,y,x,st,c,b,a,rg,lf,dw,up}, active-low
  output logic        p1,
  output logic        p2,
  output logic        p3,
  output logic        p4,
  output logic        p6,
  output logic        p9
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int UP = 0, DW = 1, LF = 2, RG = 3, A = 4, B = 5, C = 6, ST = 7;
  localparam int X = 8, Y = 9, Z = 10, MD = 11;

  // bit 11 = TH, bits 10:0 = every button except MODE
  logic [SYNC_STAGES-1:0][11:0] sync_q;
  logic [SYNC_STAGES-1:0]       md_sync;
  logic                         th_s;
  logic [11:0]                  btn_s, btn_c, btn_r;
  logic                         th_r, fall, six_en;
  logic [2:0]                   fc, fc_sel;
  logic [TW-1:0]                tmr;
  logic [5:0]                   nxt, pins;   // {p9,p6,p4,p3,p2,p1}

  // input synchronisers, reset to the released/high level
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], {th, btn[10:0]}};
  end

  // MODE synchroniser keeps sampling through reset so the mode can be latched
  always_ff @(posedge clk) begin
    md_sync <= {md_sync[SYNC_STAGES-2:0], btn[MD]};
  end

  assign th_s  = sync_q[SYNC_STAGES-1][11];
  assign btn_s = {md_sync[SYNC_STAGES-1], sync_q[SYNC_STAGES-1][10:0]};

`ifdef MD_DEBOUNCE_EN
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  logic [11:0][DBW-1:0] db_cnt;
  logic [11:0]          btn_db;

  // per-button debounce: accept a new level once it has been steady long enough
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt <= '0;
      btn_db <= '1;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (btn_s[i] == btn_db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          btn_db[i] <= btn_s[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end
  assign btn_c = btn_db;
`else
  assign btn_c = btn_s;
`endif

  assign fall = th_r & ~th_s;

  // count stage: align TH/buttons, count TH falls, expire an idle sequence
  always_ff @(posedge clk) begin
    if (rst) begin
      th_r  <= 1'b1;
      btn_r <= '1;
      fc    <= '0;
      tmr   <= '0;
    end else begin
      th_r  <= th_s;
      btn_r <= btn_c;
      if (fall) begin
        if (fc != 3'd4) fc <= fc + 3'd1;
        tmr <= '0;
      end else if (tmr == TW'(TIMEOUT_CYCLES - 1)) begin
        fc <= '0;
      end else begin
        tmr <= tmr + TW'(1);
      end
    end
  end

  // mode latch: the MODE level present while reset is held picks 3/6 buttons
  always_ff @(posedge clk) begin
    if (rst) six_en <= md_sync[SYNC_STAGES-1];
  end

  // DB9 pin mux; three-button pads always behave as if one edge was seen
  always_comb begin
    nxt    = '1;
    fc_sel = six_en ? fc : 3'd1;
    if (th_r) begin
      nxt[5] = btn_r[C];
      nxt[4] = btn_r[B];
      if (fc_sel == 3'd3) nxt[3:0] = {btn_r[MD], btn_r[X], btn_r[Y], btn_r[Z]};
      else                nxt[3:0] = {btn_r[RG], btn_r[LF], btn_r[DW], btn_r[UP]};
    end else begin
      nxt[5] = btn_r[ST];
      nxt[4] = btn_r[A];
      case (fc_sel)
        3'd3:    nxt[3:0] = 4'b0000;
        3'd4:    nxt[3:0] = 4'b1111;
        default: nxt[3:0] = {2'b00, btn_r[DW], btn_r[UP]};
      endcase
    end
  end

  // output register
  always_ff @(posedge clk) begin
    if (rst) pins <= '1;
    else     pins <= nxt;
  end

  assign {p9, p6, p4, p3, p2, p1} = pins;
endmodule

module md_multipad_encoder #(
  parameter int NUM_PADS        = 2,
  parameter int SYNC_STAGES     = 2,
  parameter int TIMEOUT_CYCLES  = 16000,
  parameter int DEBOUNCE_CYCLES = 5000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_PADS-1:0] p7,
  input  logic [NUM_PADS-1:0] up,
  input  logic [NUM_PADS-1:0] dw,
  input  logic [NUM_PADS-1:0] lf,
  input  logic [NUM_PADS-1:0] rg,
  input  logic [NUM_PADS-1:0] a,
  input  logic [NUM_PADS-1:0] b,
  input  logic [NUM_PADS-1:0] c,
  input  logic [NUM_PADS-1:0] st,
  input  logic [NUM_PADS-1:0] x,
  input  logic [NUM_PADS-1:0] y,
  input  logic [NUM_PADS-1:0] z,
  input  logic [NUM_PADS-1:0] md,
  output logic [NUM_PADS-1:0] p1,
  output logic [NUM_PADS-1:0] p2,
  output logic [NUM_PADS-1:0] p3,
  output logic [NUM_PADS-1:0] p4,
  output logic [NUM_PADS-1:0] p6,
  output logic [NUM_PADS-1:0] p9
);
  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    md_pad_lane #(
      .SYNC_STAGES    (SYNC_STAGES),
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_lane (
      .clk(clk),
      .rst(rst),
      .th (p7[i]),
      .btn({md[i], z[i], y[i], x[i], st[i], c[i], b[i], a[i], rg[i], lf[i], dw[i], up[i]}),
      .p1 (p1[i]),
      .p2 (p2[i]),
      .p3 (p3[i]),
      .p4 (p4[i]),
      .p6 (p6[i]),
      .p9 (p9[i])
    );
  end
endmodule

// File: tb/tb_md_multipad_encoder.sv
// Bench for md_multipad_encoder: directed TH sequences with literal expectations,
// plus a cycle-by-cycle comparison against a sequence-level model.
module tb_md_multipad_encoder;
  localparam int NP = 2, SS = 2, TO = 200, DB = 8, MAXC = 16384, PH = 20;
`ifdef MD_DEBOUNCE_EN
  localparam int BL = DB;
`else
  localparam int BL = 0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [NP-1:0] p7, up, dw, lf, rg, a, b, c, st, x, y, z, md;
  logic [NP-1:0] p1, p2, p3, p4, p6, p9;
  int checks = 0, errors = 0;

  md_multipad_encoder #(.NUM_PADS(NP), .SYNC_STAGES(SS), .TIMEOUT_CYCLES(TO),
                        .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .p7(p7), .up(up), .dw(dw), .lf(lf), .rg(rg),
    .a(a), .b(b), .c(c), .st(st), .x(x), .y(y), .z(z), .md(md),
    .p1(p1), .p2(p2), .p3(p3), .p4(p4), .p6(p6), .p9(p9));

  always #50 clk = ~clk;   // 10 MHz

  // ---------------- model ----------------
  // history of sampled inputs per pad {th,md,z,y,x,st,c,b,a,rg,lf,dw,up}
  logic [12:0] hin [NP][MAXC];
  bit          rh  [MAXC];
  int          k = -1;
  int          last_m [NP], cnt_m [NP], fc_m [NP];
  bit          six_m  [NP];
  logic [5:0]  exp_q  [NP];   // {p9,p6,p4,p3,p2,p1}

  function automatic logic [12:0] pack(int p);
    return {p7[p], md[p], z[p], y[p], x[p], st[p], c[p], b[p], a[p], rg[p], lf[p], dw[p], up[p]};
  endfunction
  function automatic logic [12:0] hin_at(int p, int i);
    return (i < 0) ? 13'h1fff : hin[p][i];
  endfunction
  function automatic bit rst_at(int i);
    return (i < 0) ? 1'b1 : rh[i];
  endfunction
  // synchronised value after edge i: input from SS-1 edges earlier, forced
  // high (except MODE) if reset was seen anywhere in that window
  function automatic logic [12:0] sync_at(int p, int i);
    logic [12:0] v;
    v = hin_at(p, i - SS + 1);
    for (int j = 0; j < SS; j++)
      if (rst_at(i - j)) begin v[10:0] = '1; v[12] = 1'b1; end
    return v;
  endfunction
  // value seen by the sequence logic after edge i
  function automatic logic [12:0] r_at(int p, int i);
    if (rst_at(i)) return 13'h1fff;
    return sync_at(p, i - 1);
  endfunction
  // DB9 pin table
  function automatic logic [5:0] mux_m(logic [12:0] v, int fc, bit six);
    int f;
    f = six ? fc : 1;
    if (v[12]) begin
      if (f == 3) return {v[6], v[5], v[11], v[8], v[9], v[10]};
      return {v[6], v[5], v[3], v[2], v[1], v[0]};
    end
    if (f == 3) return {v[7], v[4], 4'b0000};
    if (f == 4) return {v[7], v[4], 4'b1111};
    return {v[7], v[4], 2'b00, v[1], v[0]};
  endfunction

  initial begin
    logic [12:0] rk, rp, hm;
    for (int p = 0; p < NP; p++) begin
      last_m[p] = 0; cnt_m[p] = 0; fc_m[p] = 0; six_m[p] = 1'b1; exp_q[p] = '1;
    end
    forever begin
      @(posedge clk);
      k++;
      rh[k] = rst;
      for (int p = 0; p < NP; p++) hin[p][k] = pack(p);
      for (int p = 0; p < NP; p++) begin
        rk = r_at(p, k);
        rp = r_at(p, k - 1);
        exp_q[p] = rh[k] ? 6'h3f : mux_m(rp, fc_m[p], six_m[p]);
        if (rh[k]) begin
          hm = hin_at(p, k - SS);
          six_m[p] = hm[11];
          last_m[p] = k;
          cnt_m[p] = 0;
        end else if (rp[12] && !rk[12]) begin
          // sequence restarts if the previous fall is more than TO cycles back
          cnt_m[p] = (k - last_m[p] <= TO) ? ((cnt_m[p] < 4) ? cnt_m[p] + 1 : 4) : 1;
          last_m[p] = k;
        end
        fc_m[p] = (k - last_m[p] >= TO) ? 0 : cnt_m[p];
      end
    end
  end

  // ---------------- checking ----------------
  function automatic logic [5:0] dut_vec(int p);
    return {p9[p], p6[p], p4[p], p3[p], p2[p], p1[p]};
  endfunction

  task automatic check(string nm, logic [5:0] act, logic [5:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got {p9,p6,p4,p3,p2,p1}=%b expected %b at %0t", nm, act, req, $time);
    end
  endtask

  task automatic lit(string nm, int p, logic [5:0] req);
    check($sformatf("%s pad%0d dut", nm, p), dut_vec(p), req);
`ifndef MD_DEBOUNCE_EN
    check($sformatf("%s pad%0d model", nm, p), exp_q[p], req);
`endif
  endtask

`ifndef MD_DEBOUNCE_EN
  // every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    if (k >= SS + 3)
      for (int p = 0; p < NP; p++) check($sformatf("cycle pad%0d", p), dut_vec(p), exp_q[p]);
  end
`endif

  // ---------------- stimulus ----------------
  task automatic cyc(int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic phase(logic [NP-1:0] mask, logic lvl, int n);
    for (int p = 0; p < NP; p++) if (mask[p]) p7[p] = lvl;
    cyc(n);
  endtask

  initial begin
    {p7, up, dw, lf, rg, a, b, c, st, x, y, z, md} = '1;
    rst = 1'b1;
    cyc(4);
    lit("in reset", 0, 6'b111111);
    cyc(1);
    rst = 1'b0;
    cyc(3);
    lit("after reset", 0, 6'b111111);
    lit("after reset", 1, 6'b111111);

    // A+Start with TH low: first fall gives fc=1
    a[0] = 1'b0; st[0] = 1'b0; p7[0] = 1'b0;
    cyc(SS + 2 + BL);
    lit("A+Start TH0", 0, 6'b000011);
    lit("idle pad", 1, 6'b111111);
    p7[0] = 1'b1; a[0] = 1'b1; st[0] = 1'b1;
    cyc(TO + 10);

    // six-button read on pad0 with Z and MODE pressed
    z[0] = 1'b0; md[0] = 1'b0;
    cyc(PH + BL);
    phase(2'b01, 1'b0, PH); lit("six L1", 0, 6'b110011);
    phase(2'b01, 1'b1, PH);
    phase(2'b01, 1'b0, PH); lit("six L2", 0, 6'b110011);
    phase(2'b01, 1'b1, PH);
    phase(2'b01, 1'b0, PH); lit("six L3 id", 0, 6'b110000);
    phase(2'b01, 1'b1, PH); lit("six H3 xyz", 0, 6'b110110);
    phase(2'b01, 1'b0, PH); lit("six L4", 0, 6'b111111);
    phase(2'b01, 1'b1, PH);
    z[0] = 1'b1; md[0] = 1'b1;
    cyc(TO + 10);

    // timeout: two falls, idle past the timeout, then a full sequence
    phase(2'b01, 1'b0, PH); phase(2'b01, 1'b1, PH);
    phase(2'b01, 1'b0, PH); phase(2'b01, 1'b1, PH);
    cyc(TO + 5);
    phase(2'b01, 1'b0, PH); lit("timeout L1", 0, 6'b110011);
    phase(2'b01, 1'b1, PH);
    phase(2'b01, 1'b0, PH); lit("timeout L2", 0, 6'b110011);
    phase(2'b01, 1'b1, PH);
    phase(2'b01, 1'b0, PH); lit("timeout L3 id", 0, 6'b110000);
    phase(2'b01, 1'b1, PH);
    cyc(TO + 10);

    // three-button mode on pad1 only
    md[1] = 1'b0;
    cyc(4);
    rst = 1'b1; cyc(4); rst = 1'b0;
    cyc(2);
    md[1] = 1'b1; z = '0;
    cyc(PH + BL);
    phase(2'b11, 1'b0, PH); lit("3btn L1", 0, 6'b110011); lit("3btn L1", 1, 6'b110011);
    phase(2'b11, 1'b1, PH);
    phase(2'b11, 1'b0, PH);
    phase(2'b11, 1'b1, PH);
    phase(2'b11, 1'b0, PH); lit("3btn L3", 0, 6'b110000); lit("3btn L3", 1, 6'b110011);
    phase(2'b11, 1'b1, PH); lit("3btn H3", 0, 6'b111110); lit("3btn H3", 1, 6'b111111);
    phase(2'b11, 1'b0, PH); lit("3btn L4", 0, 6'b111111); lit("3btn L4", 1, 6'b110011);
    phase(2'b11, 1'b1, PH);
    cyc(TO + 10);

    // reset in the third high phase, then a fresh sequence
    phase(2'b01, 1'b0, PH); phase(2'b01, 1'b1, PH);
    phase(2'b01, 1'b0, PH); phase(2'b01, 1'b1, PH);
    phase(2'b01, 1'b0, PH);
    phase(2'b01, 1'b1, PH / 2); lit("pre-reset H3", 0, 6'b111110);
    rst = 1'b1;
    cyc(1); lit("reset mid-seq", 0, 6'b111111);
    cyc(3);
    rst = 1'b0;
    cyc(10);
    phase(2'b01, 1'b0, PH); lit("post-reset L1", 0, 6'b110011);
    phase(2'b01, 1'b1, PH);
    phase(2'b01, 1'b0, PH); lit("post-reset L2", 0, 6'b110011);
    phase(2'b01, 1'b1, PH);
    phase(2'b01, 1'b0, PH); lit("post-reset L3", 0, 6'b110000);
    phase(2'b01, 1'b1, PH);
    z = '1;
    cyc(TO + 10);

`ifdef MD_DEBOUNCE_EN
    // short glitch on B is rejected, a long press is accepted
    b[0] = 1'b0; cyc(5); b[0] = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("glitch p6 pad0", {5'b0, p6[0]}, 6'd1);
    end
    b[0] = 1'b0; cyc(20);
    check("held B p6 pad0", {5'b0, p6[0]}, 6'd0);
    b[0] = 1'b1;
    cyc(SS + DB + 4);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
